// File: rtl/adc_fill_writer_if.sv
// Port A of the ADC data memory and the write side of the ADC header FIFO,
// bundled for the fill writer (master) and the memory/FIFO wrapper (slave).
interface adc_fill_writer_if #(
    parameter int ADDR_W = 12
);
    logic              ADC_data_mem_wea;
    logic [ADDR_W-1:0] ADC_data_mem_addra;
    logic [31:0]       ADC_data_mem_dina;
    logic              ADC_header_fifo_wr_en;
    logic [31:0]       ADC_header_fifo_din;
    logic              ADC_header_fifo_full;

    modport master (
        output ADC_data_mem_wea,
        output ADC_data_mem_addra,
        output ADC_data_mem_dina,
        output ADC_header_fifo_wr_en,
        output ADC_header_fifo_din,
        input  ADC_header_fifo_full
    );

    modport slave (
        input  ADC_data_mem_wea,
        input  ADC_data_mem_addra,
        input  ADC_data_mem_dina,
        input  ADC_header_fifo_wr_en,
        input  ADC_header_fifo_din,
        output ADC_header_fifo_full
    );
endinterface

// File: rtl/adc_fill_writer.sv
// ADC fill writer: on an accepted trigger, writes FILL_LEN ADC words into a
// circular data memory, then pushes a two-word header into the header FIFO.
module adc_fill_writer #(
    parameter int ADDR_W   = 12,
    parameter int FILL_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trigger,
    input  logic [31:0]              adc_data,
    input  logic                     adc_valid,
    input  logic                     rd_fill_done,
    adc_fill_writer_if.master        bus,
    output logic                     busy,
    output logic [31:0]              fill_num,
    output logic [15:0]              drop_count
);

    localparam logic [ADDR_W:0] FL_W     = (ADDR_W+1)'(FILL_LEN);
    localparam logic [ADDR_W:0] DEPTH_W  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_CNT = FL_W - 1'b1;

    // COMMIT is the cycle in which word1 is on the FIFO bus; the fill is
    // committed at its end so busy and fill_num fall/update together.
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HDR0,
        HDR1,
        COMMIT
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   sample_cnt;
    logic [ADDR_W:0]   words_used, used_sum, used_next;
    logic              space_ok;
    logic              accept, cap_wr, hdr0_wr, hdr1_wr, commit, drop;

    assign space_ok = (DEPTH_W - words_used) >= FL_W;
    assign drop     = trigger && !accept;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cap_wr     = 1'b0;
        hdr0_wr    = 1'b0;
        hdr1_wr    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger && enable && space_ok && !bus.ADC_header_fifo_full) begin
                    accept     = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    cap_wr = 1'b1;
                    if (sample_cnt == LAST_CNT) state_next = HDR0;
                end
            end
            HDR0: begin
                if (!bus.ADC_header_fifo_full) begin
                    hdr0_wr    = 1'b1;
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (!bus.ADC_header_fifo_full) begin
                    hdr1_wr    = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer occupancy: commit adds a fill, release frees one if available.
    always_comb begin
        used_sum  = words_used;
        if (commit) used_sum = words_used + FL_W;
        used_next = used_sum;
        if (rd_fill_done && used_sum >= FL_W) used_next = used_sum - FL_W;
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr                    <= '0;
            start_addr                <= '0;
            sample_cnt                <= '0;
            words_used                <= '0;
            fill_num                  <= '0;
            drop_count                <= '0;
            busy                      <= 1'b0;
            bus.ADC_data_mem_wea      <= 1'b0;
            bus.ADC_data_mem_addra    <= '0;
            bus.ADC_data_mem_dina     <= '0;
            bus.ADC_header_fifo_wr_en <= 1'b0;
            bus.ADC_header_fifo_din   <= '0;
        end else begin
            bus.ADC_data_mem_wea <= cap_wr;
            if (accept) begin
                start_addr <= wr_ptr;
                sample_cnt <= '0;
            end
            if (cap_wr) begin
                bus.ADC_data_mem_addra <= wr_ptr;
                bus.ADC_data_mem_dina  <= adc_data;
                wr_ptr                 <= wr_ptr + 1'b1;
                sample_cnt             <= sample_cnt + 1'b1;
            end
            bus.ADC_header_fifo_wr_en <= hdr0_wr || hdr1_wr;
            if (hdr0_wr)      bus.ADC_header_fifo_din <= {fill_num[31-ADDR_W:0], start_addr};
            else if (hdr1_wr) bus.ADC_header_fifo_din <= 32'(FILL_LEN);
            if (commit) fill_num <= fill_num + 1'b1;
            words_used <= used_next;
            busy       <= (state_next != IDLE);
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_fill_writer.sv
// Bench for adc_fill_writer (ADDR_W=4, FILL_LEN=8): a per-cycle model checked
// against the DUT, plus directed scenarios with hand-computed expectations.
module tb_adc_fill_writer;
    localparam int AW    = 4;
    localparam int FL    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, enable, trigger, adc_valid, rd_fill_done, full;
    logic [31:0] adc_data;
    logic        busy;
    logic [31:0] fill_num;
    logic [15:0] drop_count;

    adc_fill_writer_if #(.ADDR_W(AW)) bus ();
    assign bus.ADC_header_fifo_full = full;

    adc_fill_writer #(.ADDR_W(AW), .FILL_LEN(FL)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trigger      (trigger),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .rd_fill_done (rd_fill_done),
        .bus          (bus.master),
        .busy         (busy),
        .fill_num     (fill_num),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];
    wr_t hlog[$];

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_on = 1'b0;
    bit          m_busy;
    int          m_left, m_hdr, m_ptr, m_start, m_used;
    logic [31:0] m_fill;
    logic [15:0] m_drop;
    bit          e_wea, e_wr_en, e_zero;
    int          e_addra;
    logic [31:0] e_dina, e_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_step();
        check("busy", 32'(busy), 32'(m_busy));
        check("fill_num", fill_num, m_fill);
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("wea", 32'(bus.ADC_data_mem_wea), 32'(e_wea));
        if (e_wea || e_zero) begin
            check("addra", 32'(bus.ADC_data_mem_addra), 32'(e_addra));
            check("dina", bus.ADC_data_mem_dina, e_dina);
        end
        check("wr_en", 32'(bus.ADC_header_fifo_wr_en), 32'(e_wr_en));
        if (e_wr_en || e_zero) check("din", bus.ADC_header_fifo_din, e_din);
        check("wr_en_while_full", 32'(bus.ADC_header_fifo_wr_en & full), 32'd0);
    endtask

    task automatic model_step();
        bit was, commit;
        e_wea   = 1'b0;
        e_wr_en = 1'b0;
        e_zero  = 1'b0;
        if (reset) begin
            m_on = 1'b1; m_busy = 1'b0; m_left = 0; m_hdr = 0; m_ptr = 0;
            m_start = 0; m_used = 0; m_fill = '0; m_drop = '0;
            e_zero = 1'b1; e_addra = 0; e_dina = '0; e_din = '0;
        end else if (m_on) begin
            was    = m_busy;
            commit = 1'b0;
            if (was) begin
                if (m_left > 0) begin
                    if (adc_valid) begin
                        e_wea = 1'b1; e_addra = m_ptr; e_dina = adc_data;
                        m_ptr = (m_ptr + 1) % DEPTH; m_left--;
                    end
                end else if (m_hdr == 2) begin
                    if (!full) begin
                        e_wr_en = 1'b1; e_din = (m_fill << AW) | 32'(m_start); m_hdr = 1;
                    end
                end else if (m_hdr == 1) begin
                    if (!full) begin
                        e_wr_en = 1'b1; e_din = 32'(FL); m_hdr = 0;
                    end
                end else begin
                    commit = 1'b1; m_busy = 1'b0; m_fill = m_fill + 1;
                end
            end
            if (trigger) begin
                if (!was && enable && (DEPTH - m_used >= FL) && !full) begin
                    m_busy = 1'b1; m_start = m_ptr; m_left = FL; m_hdr = 2;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 1;
                end
            end
            if (commit) m_used += FL;
            if (rd_fill_done && m_used >= FL) m_used -= FL;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        adc_data = 32'(cyc);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fill_num"}, fill_num, 32'd0);
        check({tag, "_drop"}, 32'(drop_count), 32'd0);
        check({tag, "_wea"}, 32'(bus.ADC_data_mem_wea), 32'd0);
        check({tag, "_addra"}, 32'(bus.ADC_data_mem_addra), 32'd0);
        check({tag, "_dina"}, bus.ADC_data_mem_dina, 32'd0);
        check({tag, "_wr_en"}, 32'(bus.ADC_header_fifo_wr_en), 32'd0);
        check({tag, "_din"}, bus.ADC_header_fifo_din, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1; enable = 1'b1; trigger = 1'b0; adc_valid = 1'b0;
        rd_fill_done = 1'b0; full = 1'b0; adc_data = '0;
        fork
            forever begin
                @(negedge clk);
                if (m_on) begin
                    compare_step();
                    if (bus.ADC_data_mem_wea === 1'b1)
                        wlog.push_back('{cyc, 32'(bus.ADC_data_mem_addra), bus.ADC_data_mem_dina});
                    if (bus.ADC_header_fifo_wr_en === 1'b1)
                        hlog.push_back('{cyc, 32'd0, bus.ADC_header_fifo_din});
                end
                model_step();
            end
            begin
                // reset values
                repeat (3) tick();
                check_zero_outputs("reset");
                reset = 1'b0; adc_valid = 1'b1;
                tick();

                // basic fill
                wlog.delete(); hlog.delete();
                t = cyc;
                pulse_trigger();
                check("basic_busy_t1", 32'(busy), 32'd1);
                wait_idle(40);
                check("basic_latency", 32'(cyc - t), 32'd12);
                check("basic_nwr", 32'(wlog.size()), 32'd8);
                for (int i = 0; i < 8; i++) begin
                    check("basic_addr", wlog[i].a, 32'(i));
                    check("basic_data", wlog[i].d, 32'(t + 1 + i));
                    check("basic_wcyc", 32'(wlog[i].c), 32'(t + 2 + i));
                end
                check("basic_nhdr", 32'(hlog.size()), 32'd2);
                check("basic_w0", hlog[0].d, 32'h0000_0000);
                check("basic_w1", hlog[1].d, 32'h0000_0008);
                check("basic_w0cyc", 32'(hlog[0].c), 32'(t + 10));
                check("basic_w1cyc", 32'(hlog[1].c), 32'(t + 11));
                check("basic_fill_num", fill_num, 32'd1);

                // stall with adc_valid toggling
                wlog.delete(); hlog.delete();
                pulse_trigger();
                for (int n = 0; n < 60 && busy !== 1'b0; n++) begin
                    adc_valid = ~adc_valid;
                    tick();
                end
                adc_valid = 1'b1;
                wait_idle(10);
                check("stall_nwr", 32'(wlog.size()), 32'd8);
                for (int i = 0; i < 8; i++) check("stall_addr", wlog[i].a, 32'(8 + i));
                check("stall_w0", hlog[0].d, 32'h0000_0018);
                check("stall_w1", hlog[1].d, 32'h0000_0008);

                // buffer full: trigger dropped
                wlog.delete(); hlog.delete();
                pulse_trigger();
                repeat (3) tick();
                check("nospace_drop", 32'(drop_count), 32'd1);
                check("nospace_busy", 32'(busy), 32'd0);
                check("nospace_nwr", 32'(wlog.size()), 32'd0);

                // release one fill, then fill with header backpressure
                rd_fill_done = 1'b1; tick(); rd_fill_done = 1'b0;
                wlog.delete(); hlog.delete();
                t = cyc;
                pulse_trigger();
                repeat (8) tick();
                full = 1'b1;
                repeat (5) tick();
                full = 1'b0;
                wait_idle(20);
                check("bp_latency", 32'(cyc - t), 32'd17);
                check("bp_nhdr", 32'(hlog.size()), 32'd2);
                check("bp_w0cyc", 32'(hlog[0].c), 32'(t + 15));
                check("bp_w0", hlog[0].d, 32'h0000_0020);
                check("bp_w1", hlog[1].d, 32'h0000_0008);
                check("wrap_addr0", wlog[0].a, 32'd0);
                check("wrap_addr7", wlog[7].a, 32'd7);

                // drop conditions
                rd_fill_done = 1'b1; tick(); tick(); rd_fill_done = 1'b0;
                enable = 1'b0; pulse_trigger(); enable = 1'b1;
                check("drop_enable", 32'(drop_count), 32'd2);
                check("drop_enable_busy", 32'(busy), 32'd0);
                full = 1'b1; pulse_trigger(); full = 1'b0;
                check("drop_full", 32'(drop_count), 32'd3);
                check("drop_full_busy", 32'(busy), 32'd0);
                wlog.delete(); hlog.delete();
                pulse_trigger();
                tick();
                pulse_trigger();
                check("drop_busy", 32'(drop_count), 32'd4);
                wait_idle(20);
                check("drop_ptr_addr", wlog[0].a, 32'd8);
                check("drop_w0", hlog[0].d, 32'h0000_0038);
                check("drop_fill_num", fill_num, 32'd4);

                // release in the commit cycle
                t = cyc;
                pulse_trigger();
                repeat (10) tick();
                rd_fill_done = 1'b1; tick(); rd_fill_done = 1'b0;
                check("simul_busy", 32'(busy), 32'd0);
                check("simul_fill_num", fill_num, 32'd5);
                pulse_trigger();
                check("simul_accept", 32'(busy), 32'd1);
                check("simul_drop", 32'(drop_count), 32'd4);
                wait_idle(20);

                // reset mid-fill
                rd_fill_done = 1'b1; tick(); rd_fill_done = 1'b0;
                wlog.delete(); hlog.delete();
                pulse_trigger();
                repeat (3) tick();
                reset = 1'b1;
                tick();
                check_zero_outputs("midrst");
                check("midrst_nwr", 32'(wlog.size()), 32'd3);
                reset = 1'b0;
                tick(); tick();
                check("midrst_nhdr", 32'(hlog.size()), 32'd0);
                wlog.delete(); hlog.delete();
                pulse_trigger();
                wait_idle(20);
                check("postrst_addr0", wlog[0].a, 32'd0);
                check("postrst_w0", hlog[0].d, 32'h0000_0000);
                check("postrst_fill_num", fill_num, 32'd1);

                tick();
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end
endmodule
